cdc_handshake_tx: RTL
=====================

Name: cdc_handshake_tx

Overview:
- Source-domain end of a 4-phase req/ack clock-domain crossing that transfers a DATA_WIDTH word to another clock domain.
- Accepts a word through a valid/ready interface and holds it stable on o_data.
- Drives a registered level request toward the destination-side synchronizer.
- Synchronizes the returning acknowledge internally and completes the full four-phase return-to-zero sequence before accepting the next word.

Parameters:
- DATA_WIDTH, 8: width of transferred word.
- SYNC_STAGES, 3: flip-flops in the i_ack synchronizer chain; legal range 2..4.

Ports:
- clk, input, 1: source-domain clock; all state updates on posedge.
- rst, input, 1: asynchronous, active-high reset.
- i_valid, input, 1: upstream has a word on i_data.
- o_ready, output, 1: block can accept a word; combinational, equals (state==IDLE).
- i_data, input, DATA_WIDTH: word to transfer; sampled only on accept.
- o_req, output, 1: registered request level to the destination domain.
- o_data, output, DATA_WIDTH: registered data, stable whenever o_req=1 and until next accept.
- i_ack, input, 1: asynchronous acknowledge from the destination domain.
- o_busy, output, 1: registered; high from accept until handshake completes.
- o_done, output, 1: registered one-cycle pulse when the handshake returns to zero.

Behaviour:
- Reset (async assert, sync release by system):
  - state=IDLE, o_req=0, o_data=0, o_busy=0, o_done=0.
  - Sync chain all 0; o_ready=1 after reset.
- ack_s = last stage of a SYNC_STAGES shift chain sampling i_ack each posedge. ack_s is the only form of i_ack used anywhere.
- Accept: i_valid & o_ready at a posedge. On that edge:
  - o_data<=i_data, o_req<=1, o_busy<=1, state->REQ.
- REQ:
  - Hold o_req=1 and o_data until ack_s=1.
  - On the edge where ack_s=1: o_req<=0, state->ACK_LOW.
  - With SYNC_STAGES=S, o_req falls at the (S+1)th posedge after i_ack rises; i_ack changes between edges.
- ACK_LOW:
  - o_req=0; wait for ack_s=0.
  - On that edge: state->IDLE, o_busy<=0, o_done<=1 for exactly one cycle.
  - o_ready is high in the cycle o_done is high. The earliest next accept is the edge ending that cycle.
- o_data changes only on accept. It never changes while o_req=1 or during ACK_LOW.
- i_valid in REQ/ACK_LOW is ignored; o_ready=0 and the upstream holds.
- ack_s=1 while IDLE is ignored and causes no state change. The next accept still asserts o_req. REQ then completes on the first edge with ack_s=1, which the destination must not produce for a new req.
- Minimum transaction: 1 (accept) + S+1 (ack rise seen) + S+1 (ack fall seen) cycles, plus the destination latency.
- Reset mid-transaction:
  - o_req drops asynchronously and state->IDLE.
  - The sync chain clears, so a stale ack_s is lost.
  - The destination must tolerate a truncated request. No o_done is issued for the aborted word.
- No combinational path from i_ack to any output. o_ready depends only on state.

Test Plan:
- Reset: assert rst mid-cycle with clock running → o_req=0, o_data=0x00, o_busy=0, o_done=0 immediately; o_ready=1 after release.
- Single transfer, S=3:
  - Stimulus: i_data=0xA5 with i_valid for one edge; destination model raises i_ack 4 cycles after seeing o_req, and drops i_ack 2 cycles after o_req falls.
  - Required: o_data=0xA5 with o_req=1 the cycle after accept; o_req falls 4 edges after i_ack rises; o_done pulses once, 4 edges after i_ack falls; o_busy covers the whole interval.
- Backpressure: i_valid held high with i_data changing 0x11→0x22→0x33 while busy → each word accepted only when o_ready=1; o_data never changes while o_req=1 or during ACK_LOW; each accepted word produces exactly one o_done.
- Back-to-back: i_valid continuously high with i_data=0x01,0x02 → the second accept occurs on the edge ending the o_done cycle; o_req rises again with o_data=0x02.
- Spurious ack: pulse i_ack high for 10 cycles while IDLE → no output change; o_done stays 0.
- Abort: assert rst while in REQ with o_data=0x5A → o_req=0 and o_data=0x00 asynchronously; after release o_ready=1 and a new transfer of 0x3C completes normally.

Source files
------------

// File: rtl/cdc_handshake_tx.sv
// Source-domain end of a four-phase req/ack crossing: latches one word, raises a level request and
// returns to zero only after the synchronized acknowledge has risen and fallen again.
module cdc_handshake_tx #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_req,
  output logic [DATA_WIDTH-1:0] o_data,
  input  logic                  i_ack,
  output logic                  o_busy,
  output logic                  o_done
);

  // IDLE: waiting for a word | REQ: o_req high, waiting for ack_s | ACK_LOW: waiting for ack_s to drop
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    ACK_LOW = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [SYNC_STAGES-1:0]  r_ack_sync;
  logic                    w_ack_s;
  logic                    r_req;
  logic                    r_busy;
  logic                    r_done;
  logic [DATA_WIDTH-1:0]   r_data;
  logic                    w_req_nxt;
  logic                    w_busy_nxt;
  logic                    w_done_nxt;
  logic                    w_load;

  // Only the last synchronizer stage is ever looked at; i_ack itself feeds nothing else.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ack_sync <= '0;
    end else begin
      r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], i_ack};
    end
  end

  assign w_ack_s = r_ack_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_req   <= w_req_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      if (w_load) begin
        r_data <= i_data;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req_nxt   = r_req;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      IDLE: begin
        // A stale ack_s here is deliberately ignored.
        if (i_valid) begin
          w_load      = 1'b1;
          w_req_nxt   = 1'b1;
          w_busy_nxt  = 1'b1;
          w_state_nxt = REQ;
        end
      end
      REQ: begin
        if (w_ack_s) begin
          w_req_nxt   = 1'b0;
          w_state_nxt = ACK_LOW;
        end
      end
      ACK_LOW: begin
        if (!w_ack_s) begin
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_req_nxt   = 1'b0;
        w_busy_nxt  = 1'b0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign o_ready = (r_state == IDLE);
  assign o_req   = r_req;
  assign o_data  = r_data;
  assign o_busy  = r_busy;
  assign o_done  = r_done;

endmodule
